// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, write masks,
// interrupt cause codes, the privilege type and the CSR snapshot struct.
package csr_pkg;

    localparam int CSR_W = 64;

    localparam logic [11:0] CSR_MSTATUS      = 12'h300;
    localparam logic [11:0] CSR_MIE          = 12'h304;
    localparam logic [11:0] CSR_MTVEC        = 12'h305;
    localparam logic [11:0] CSR_MHPMEVENT3   = 12'h323;
    localparam logic [11:0] CSR_MSCRATCH     = 12'h340;
    localparam logic [11:0] CSR_MEPC         = 12'h341;
    localparam logic [11:0] CSR_MCAUSE       = 12'h342;
    localparam logic [11:0] CSR_MTVAL        = 12'h343;
    localparam logic [11:0] CSR_MIP          = 12'h344;
    localparam logic [11:0] CSR_MCYCLE       = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET     = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3 = 12'hB03;
    localparam logic [11:0] CSR_MHARTID      = 12'hF14;

    // mstatus keeps only MIE, MPIE and MPP; mtvec keeps BASE and both MODE bits.
    localparam logic [CSR_W-1:0] MSTATUS_MASK = 64'h0000_0000_0000_1888;
    localparam logic [CSR_W-1:0] MTVEC_MASK   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [CSR_W-1:0] MIE_MASK     = 64'h0000_0000_0000_0888;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MSTATUS_MPP  = 11;

    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_MTI = 4'd7;
    localparam logic [3:0] IRQ_MEI = 4'd11;

    typedef enum logic [1:0] {
        MODE_U = 2'b00,
        MODE_M = 2'b11
    } mode_t;

    typedef struct packed {
        logic [CSR_W-1:0] mstatus;
        logic [CSR_W-1:0] mie;
        logic [CSR_W-1:0] mip;
        logic [CSR_W-1:0] mtvec;
        logic [1:0]       mtvec_mode;
        logic [CSR_W-1:0] mscratch;
        logic [CSR_W-1:0] mepc;
        logic [CSR_W-1:0] mcause;
        logic [CSR_W-1:0] mtval;
        logic [CSR_W-1:0] mcycle;
        logic [CSR_W-1:0] minstret;
        mode_t            priv;
    } csr_pack;

    // Only U and M exist, so any other MPP encoding collapses to U.
    function automatic logic [1:0] legal_mpp(input logic [1:0] v);
        return (v == 2'b11) ? 2'b11 : 2'b00;
    endfunction

endpackage

// File: rtl/csr_irq_arb.sv
// Fixed-priority machine interrupt selector: MEI > MSI > MTI.
module csr_irq_arb
    import csr_pkg::*;
(
    input  logic [2:0] irq_ip,       // {MEIP, MTIP, MSIP}
    input  logic [2:0] irq_ie,       // {MEIE, MTIE, MSIE}
    input  logic       global_ie,
    output logic       irq_pending,
    output logic [3:0] irq_cause
);

    logic [2:0] active;

    always_comb begin
        active    = irq_ip & irq_ie;
        irq_cause = 4'd0;
        if (active[2]) begin
            irq_cause = IRQ_MEI;
        end else if (active[0]) begin
            irq_cause = IRQ_MSI;
        end else if (active[1]) begin
            irq_cause = IRQ_MTI;
        end
        irq_pending = global_ie & (|active);
    end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry/exit sequencing and counters.
// Build option CSR_HPM_EN adds NUM_HPMC event counters at mhpmcounter3 onward.
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter int          XLEN     = 64,
    parameter int unsigned HARTID   = 0,
    parameter int          NUM_HPMC = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [11:0]         rd_addr,
    output logic [XLEN-1:0]     rd_data,
    output logic                rd_illegal,
    input  logic                wr_en,
    input  logic [11:0]         wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                retire,
    input  logic [NUM_HPMC-1:0] hpm_event,
    input  logic                trap_valid,
    input  logic                trap_is_irq,
    input  logic [3:0]          trap_cause,
    input  logic [XLEN-1:0]     trap_pc,
    input  logic [XLEN-1:0]     trap_tval,
    input  logic                mret,
    input  logic                irq_timer,
    input  logic                irq_soft,
    input  logic                irq_ext,
    output logic                irq_pending,
    output logic [3:0]          irq_cause,
    output logic                redirect,
    output logic [XLEN-1:0]     redirect_pc,
    output logic [1:0]          priv,
    output csr_pack             csrs
);

    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] mie_q, mie_d;
    logic [XLEN-1:0] mip_q, mip_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [XLEN-1:0] mcycle_q, mcycle_d;
    logic [XLEN-1:0] minstret_q, minstret_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            redirect_q, redirect_d;
    mode_t           priv_q, priv_d;
    logic [XLEN-1:0] trap_target;

`ifdef CSR_HPM_EN
    logic [XLEN-1:0] hpm_q [NUM_HPMC];
    logic [XLEN-1:0] hpm_d [NUM_HPMC];
`else
    logic unused_hpm_event;
    assign unused_hpm_event = ^hpm_event;
`endif

    // Vectoring applies to interrupts only, and only for MODE 1.
    always_comb begin
        trap_target = {mtvec_q[XLEN-1:2], 2'b00};
        if (mtvec_q[1:0] == 2'b01 && trap_is_irq) begin
            trap_target = trap_target + (XLEN'(trap_cause) << 2);
        end
    end

    always_comb begin
        mstatus_d     = mstatus_q;
        mie_d         = mie_q;
        mtvec_d       = mtvec_q;
        mscratch_d    = mscratch_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mtval_d       = mtval_q;
        priv_d        = priv_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        mip_d         = '0;
        mip_d[3]      = irq_soft;
        mip_d[7]      = irq_timer;
        mip_d[11]     = irq_ext;
        mcycle_d      = mcycle_q + XLEN'(1);
        minstret_d    = minstret_q + XLEN'(retire);
`ifdef CSR_HPM_EN
        for (int i = 0; i < NUM_HPMC; i++) begin
            hpm_d[i] = hpm_q[i] + XLEN'(hpm_event[i]);
        end
`endif
        if (trap_valid) begin
            mepc_d                                     = trap_pc & ~XLEN'(3);
            mcause_d                                   = XLEN'(trap_cause);
            mcause_d[XLEN-1]                           = trap_is_irq;
            mtval_d                                    = trap_tval;
            mstatus_d[MSTATUS_MPIE]                    = mstatus_q[MSTATUS_MIE];
            mstatus_d[MSTATUS_MIE]                     = 1'b0;
            mstatus_d[MSTATUS_MPP+1:MSTATUS_MPP]       = priv_q;
            priv_d                                     = MODE_M;
            redirect_d                                 = 1'b1;
            redirect_pc_d                              = trap_target;
        end else if (mret) begin
            mstatus_d[MSTATUS_MIE]                     = mstatus_q[MSTATUS_MPIE];
            mstatus_d[MSTATUS_MPIE]                    = 1'b1;
            mstatus_d[MSTATUS_MPP+1:MSTATUS_MPP]       = MODE_U;
            priv_d = mode_t'(legal_mpp(mstatus_q[MSTATUS_MPP+1:MSTATUS_MPP]));
            redirect_d                                 = 1'b1;
            redirect_pc_d                              = mepc_q;
        end else if (wr_en) begin
            // A write to a counter replaces that counter's increment this cycle.
            case (wr_addr)
                CSR_MSTATUS: begin
                    mstatus_d = wr_data & XLEN'(MSTATUS_MASK);
                    mstatus_d[MSTATUS_MPP+1:MSTATUS_MPP] =
                        legal_mpp(wr_data[MSTATUS_MPP+1:MSTATUS_MPP]);
                end
                CSR_MIE:      mie_d      = wr_data & XLEN'(MIE_MASK);
                CSR_MTVEC:    mtvec_d    = wr_data & XLEN'(MTVEC_MASK);
                CSR_MSCRATCH: mscratch_d = wr_data;
                CSR_MEPC:     mepc_d     = wr_data;
                CSR_MCAUSE:   mcause_d   = wr_data;
                CSR_MTVAL:    mtval_d    = wr_data;
                CSR_MCYCLE:   mcycle_d   = wr_data;
                CSR_MINSTRET: minstret_d = wr_data;
                default: ;
            endcase
`ifdef CSR_HPM_EN
            for (int i = 0; i < NUM_HPMC; i++) begin
                if (wr_addr == CSR_MHPMCOUNTER3 + 12'(i)) begin
                    hpm_d[i] = wr_data;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_q     <= '0;
            mie_q         <= '0;
            mip_q         <= '0;
            mtvec_q       <= '0;
            mscratch_q    <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            mcycle_q      <= '0;
            minstret_q    <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            priv_q        <= MODE_M;
        end else begin
            mstatus_q     <= mstatus_d;
            mie_q         <= mie_d;
            mip_q         <= mip_d;
            mtvec_q       <= mtvec_d;
            mscratch_q    <= mscratch_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mtval_q       <= mtval_d;
            mcycle_q      <= mcycle_d;
            minstret_q    <= minstret_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            priv_q        <= priv_d;
        end
    end

`ifdef CSR_HPM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_HPMC; i++) begin
                hpm_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_HPMC; i++) begin
                hpm_q[i] <= hpm_d[i];
            end
        end
    end
`endif

    // Counter and event address ranges stay legal even without the counters.
    always_comb begin
        rd_data    = '0;
        rd_illegal = 1'b0;
        case (rd_addr)
            CSR_MSTATUS:  rd_data = mstatus_q;
            CSR_MIE:      rd_data = mie_q;
            CSR_MTVEC:    rd_data = mtvec_q;
            CSR_MSCRATCH: rd_data = mscratch_q;
            CSR_MEPC:     rd_data = mepc_q;
            CSR_MCAUSE:   rd_data = mcause_q;
            CSR_MTVAL:    rd_data = mtval_q;
            CSR_MIP:      rd_data = mip_q;
            CSR_MCYCLE:   rd_data = mcycle_q;
            CSR_MINSTRET: rd_data = minstret_q;
            CSR_MHARTID:  rd_data = XLEN'(HARTID);
            default:      rd_illegal = 1'b1;
        endcase
        for (int i = 0; i < NUM_HPMC; i++) begin
            if (rd_addr == CSR_MHPMCOUNTER3 + 12'(i)) begin
                rd_illegal = 1'b0;
`ifdef CSR_HPM_EN
                rd_data    = hpm_q[i];
`endif
            end
            if (rd_addr == CSR_MHPMEVENT3 + 12'(i)) begin
                rd_illegal = 1'b0;
            end
        end
    end

    csr_irq_arb u_irq_arb (
        .irq_ip      ({mip_q[11], mip_q[7], mip_q[3]}),
        .irq_ie      ({mie_q[11], mie_q[7], mie_q[3]}),
        .global_ie   (mstatus_q[MSTATUS_MIE]),
        .irq_pending (irq_pending),
        .irq_cause   (irq_cause)
    );

    always_comb begin
        csrs            = '0;
        csrs.mstatus    = CSR_W'(mstatus_q);
        csrs.mie        = CSR_W'(mie_q);
        csrs.mip        = CSR_W'(mip_q);
        csrs.mtvec      = CSR_W'(mtvec_q);
        csrs.mtvec_mode = mtvec_q[1:0];
        csrs.mscratch   = CSR_W'(mscratch_q);
        csrs.mepc       = CSR_W'(mepc_q);
        csrs.mcause     = CSR_W'(mcause_q);
        csrs.mtval      = CSR_W'(mtval_q);
        csrs.mcycle     = CSR_W'(mcycle_q);
        csrs.minstret   = CSR_W'(minstret_q);
        csrs.priv       = priv_q;
    end

    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign priv        = priv_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: read probes and redirects are queued as
// expectations and checked by a negedge monitor.
module tb_csr_trap_unit;
    import csr_pkg::*;

    localparam int          XLEN     = 64;
    localparam int          NUM_HPMC = 2;
    localparam int unsigned HARTID   = 42;
    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

    logic                clk;
    logic                rst_n;
    logic [11:0]         rd_addr;
    logic [XLEN-1:0]     rd_data;
    logic                rd_illegal;
    logic                wr_en;
    logic [11:0]         wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                retire;
    logic [NUM_HPMC-1:0] hpm_event;
    logic                trap_valid;
    logic                trap_is_irq;
    logic [3:0]          trap_cause;
    logic [XLEN-1:0]     trap_pc;
    logic [XLEN-1:0]     trap_tval;
    logic                mret;
    logic                irq_timer;
    logic                irq_soft;
    logic                irq_ext;
    logic                irq_pending;
    logic [3:0]          irq_cause;
    logic                redirect;
    logic [XLEN-1:0]     redirect_pc;
    logic [1:0]          priv;
    csr_pack             csrs;

    csr_trap_unit #(.XLEN(XLEN), .HARTID(HARTID), .NUM_HPMC(NUM_HPMC)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_illegal(rd_illegal),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .retire(retire), .hpm_event(hpm_event),
        .trap_valid(trap_valid), .trap_is_irq(trap_is_irq), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .trap_tval(trap_tval), .mret(mret),
        .irq_timer(irq_timer), .irq_soft(irq_soft), .irq_ext(irq_ext),
        .irq_pending(irq_pending), .irq_cause(irq_cause),
        .redirect(redirect), .redirect_pc(redirect_pc), .priv(priv), .csrs(csrs)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic rd_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // mcycle reference: reset to 0, load on an unpreempted write, else count.
    logic [XLEN-1:0] mcycle_m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mcycle_m <= '0;
        else if (wr_en && !trap_valid && !mret && wr_addr == CSR_MCYCLE) mcycle_m <= wr_data;
        else mcycle_m <= mcycle_m + 1;
    end

    // Scoreboard queues
    logic [XLEN:0]   exp_q[$];
    string           rd_name_q[$];
    logic [XLEN-1:0] redir_exp_q[$];
    int              redir_due_q[$];
    string           redir_name_q[$];

    logic [XLEN:0]   mon_exp;
    logic [XLEN-1:0] mon_pc;
    string           mon_name;

    // Monitor
    always @(negedge clk) begin
        if (rd_req) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_probe: read seen with no expectation queued");
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = rd_name_q.pop_front();
                if ({rd_illegal, rd_data} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL %s: got illegal=%0b data=%h, want illegal=%0b data=%h",
                             mon_name, rd_illegal, rd_data, mon_exp[XLEN], mon_exp[XLEN-1:0]);
                end
            end
        end
        n_tests++;
        if (redir_due_q.size() != 0 && cyc >= redir_due_q[0]) begin
            void'(redir_due_q.pop_front());
            mon_pc   = redir_exp_q.pop_front();
            mon_name = redir_name_q.pop_front();
            if (redirect !== 1'b1 || redirect_pc !== mon_pc) begin
                n_fail++;
                $display("FAIL %s: got redirect=%0b pc=%h, want redirect=1 pc=%h",
                         mon_name, redirect, redirect_pc, mon_pc);
            end
        end else if (redirect !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_redirect: got redirect=%0b pc=%h, want redirect=0",
                     redirect, redirect_pc);
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
        wr_en      = 1'b0;
        trap_valid = 1'b0;
        mret       = 1'b0;
        retire     = 1'b0;
        rd_req     = 1'b0;
        hpm_event  = '0;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [XLEN-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
    endtask

    task automatic probe(input string nm, input logic [11:0] a,
                         input logic [XLEN-1:0] d, input logic ill = 1'b0);
        rd_addr = a;
        rd_req  = 1'b1;
        exp_q.push_back({ill, d});
        rd_name_q.push_back(nm);
        step();
    endtask

    task automatic set_trap(input logic irq, input logic [3:0] cause,
                            input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tval);
        trap_valid  = 1'b1;
        trap_is_irq = irq;
        trap_cause  = cause;
        trap_pc     = pc;
        trap_tval   = tval;
    endtask

    task automatic expect_redirect(input string nm, input logic [XLEN-1:0] pc);
        redir_exp_q.push_back(pc);
        redir_due_q.push_back(cyc + 1);
        redir_name_q.push_back(nm);
    endtask

    task automatic check(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL timeout: bench did not complete within time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        rst_n = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        retire = 1'b0; hpm_event = '0; trap_valid = 1'b0; trap_is_irq = 1'b0;
        trap_cause = '0; trap_pc = '0; trap_tval = '0; mret = 1'b0;
        irq_timer = 1'b0; irq_soft = 1'b0; irq_ext = 1'b0;

        // Reset
        step();
        check("rst_priv", XLEN'(priv), 64'd3);
        check("rst_redirect", XLEN'(redirect), 64'd0);
        check("rst_redirect_pc", redirect_pc, 64'd0);
        check("rst_irq_pending", XLEN'(irq_pending), 64'd0);
        probe("rst_mhartid", CSR_MHARTID, 64'd42);
        probe("rst_mstatus", CSR_MSTATUS, 64'd0);
        rst_n = 1'b1;
        step();
        probe("mcycle_after_release", CSR_MCYCLE, 64'd1);
        probe("unimpl_read", 12'h7C0, 64'd0, 1'b1);
        csr_write(CSR_MHARTID, 64'd0);
        probe("mhartid_write_ignored", CSR_MHARTID, 64'd42);

        // Vectored interrupt
        csr_write(CSR_MTVEC, 64'h8000_0001);
        probe("mtvec", CSR_MTVEC, 64'h8000_0001);
        set_trap(1'b1, 4'd7, 64'h1002, 64'h55);
        expect_redirect("vec_irq_redirect", 64'h8000_001C);
        step();
        check("vec_snapshot_mepc", csrs.mepc, 64'h1000);
        check("vec_snapshot_mode", XLEN'(csrs.mtvec_mode), 64'd1);
        probe("vec_mepc", CSR_MEPC, 64'h1000);
        probe("vec_mcause", CSR_MCAUSE, 64'h8000_0000_0000_0007);
        probe("vec_mtval", CSR_MTVAL, 64'h55);
        probe("vec_mstatus", CSR_MSTATUS, 64'h1800);

        // Exception then return from user mode
        csr_write(CSR_MSTATUS, 64'h88);
        mret = 1'b1;
        expect_redirect("mret_to_user", 64'h1000);
        step();
        check("priv_user", XLEN'(priv), 64'd0);
        probe("mstatus_after_mret", CSR_MSTATUS, 64'h88);
        set_trap(1'b0, 4'd8, 64'h2000, 64'h0);
        expect_redirect("exc_direct_target", 64'h8000_0000);
        step();
        check("exc_priv_m", XLEN'(priv), 64'd3);
        mret = 1'b1;
        expect_redirect("b2b_mret", 64'h2000);
        probe("exc_mstatus_mpp_u", CSR_MSTATUS, 64'h80);
        check("b2b_priv_restored", XLEN'(priv), 64'd0);
        probe("b2b_mstatus", CSR_MSTATUS, 64'h88);
        probe("exc_mcause", CSR_MCAUSE, 64'd8);
        set_trap(1'b0, 4'd2, 64'h3006, 64'h0);
        expect_redirect("exc2_target", 64'h8000_0000);
        step();
        probe("exc2_mepc_aligned", CSR_MEPC, 64'h3004);

        // Simultaneous events
        csr_write(CSR_MSCRATCH, 64'h1234);
        wr_en = 1'b1; wr_addr = CSR_MSCRATCH; wr_data = 64'hDEAD;
        set_trap(1'b0, 4'd3, 64'h4000, 64'h0);
        expect_redirect("trap_over_write", 64'h8000_0000);
        step();
        probe("mscratch_kept_trap", CSR_MSCRATCH, 64'h1234);
        probe("mstatus_trap_from_m", CSR_MSTATUS, 64'h1800);
        wr_en = 1'b1; wr_addr = CSR_MSCRATCH; wr_data = 64'hBEEF;
        mret = 1'b1;
        expect_redirect("mret_over_write", 64'h4000);
        step();
        check("mret_priv_m", XLEN'(priv), 64'd3);
        probe("mscratch_kept_mret", CSR_MSCRATCH, 64'h1234);
        csr_write(CSR_MCYCLE, 64'd5);
        probe("mcycle_written", CSR_MCYCLE, 64'd5);
        probe("mcycle_counts_on", CSR_MCYCLE, 64'd6);

        // Interrupt arbitration
        csr_write(CSR_MIE, ONES);
        probe("mie_masked", CSR_MIE, 64'h888);
        csr_write(CSR_MSTATUS, ONES);
        probe("mstatus_masked", CSR_MSTATUS, 64'h1888);
        irq_timer = 1'b1; irq_ext = 1'b1;
        check("irq_not_yet", XLEN'(irq_pending), 64'd0);
        step();
        check("irq_pending", XLEN'(irq_pending), 64'd1);
        check("irq_cause_ext", XLEN'(irq_cause), 64'd11);
        probe("mip_ext_timer", CSR_MIP, 64'h880);
        irq_ext = 1'b0;
        step();
        check("irq_cause_timer", XLEN'(irq_cause), 64'd7);
        irq_soft = 1'b1;
        step();
        check("irq_cause_soft", XLEN'(irq_cause), 64'd3);
        csr_write(CSR_MIP, 64'd0);
        probe("mip_write_ignored", CSR_MIP, 64'h088);
        csr_write(CSR_MSTATUS, 64'd0);
        check("irq_masked_global", XLEN'(irq_pending), 64'd0);
        irq_timer = 1'b0; irq_soft = 1'b0;

        // Event counters
        csr_write(CSR_MHPMCOUNTER3, 64'h77);
        hpm_event = 2'b11;
        step();
`ifdef CSR_HPM_EN
        probe("hpm3", CSR_MHPMCOUNTER3, 64'h78);
        probe("hpm4", CSR_MHPMCOUNTER3 + 12'd1, 64'd1);
`else
        probe("hpm3_absent", CSR_MHPMCOUNTER3, 64'd0);
        probe("hpm4_absent", CSR_MHPMCOUNTER3 + 12'd1, 64'd0);
`endif
        probe("hpmevent3_zero", CSR_MHPMEVENT3, 64'd0);

        // Counter wrap
        csr_write(CSR_MINSTRET, ONES);
        retire = 1'b1;
        probe("minstret_all_ones", CSR_MINSTRET, ONES);
        probe("minstret_wrapped", CSR_MINSTRET, 64'd0);
        probe("mcycle_unaffected", CSR_MCYCLE, mcycle_m);
        wr_en = 1'b1; wr_addr = CSR_MINSTRET; wr_data = 64'd10; retire = 1'b1;
        step();
        probe("minstret_write_wins", CSR_MINSTRET, 64'd10);
        retire = 1'b1;
        step();
        retire = 1'b1;
        step();
        probe("minstret_counts", CSR_MINSTRET, 64'd12);

        // Reset mid-trap
        set_trap(1'b0, 4'd5, 64'h5000, 64'h0);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        trap_valid = 1'b0;
        check("midrst_redirect", XLEN'(redirect), 64'd0);
        check("midrst_priv", XLEN'(priv), 64'd3);
        rst_n = 1'b1;
        step();
        check("postrst_redirect", XLEN'(redirect), 64'd0);
        probe("postrst_mepc", CSR_MEPC, 64'd0);
        probe("postrst_mscratch", CSR_MSCRATCH, 64'd0);
        probe("postrst_mcycle", CSR_MCYCLE, mcycle_m);

        step();
        step();
        check("rd_queue_drained", XLEN'(exp_q.size()), 64'd0);
        check("redir_queue_drained", XLEN'(redir_exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_trap_unit.md
# csr_trap_unit

Parametrised machine-mode CSR file with integrated trap sequencing: holds the M-mode CSR state, counts cycles, retired instructions and optional performance events, and arbitrates exception, interrupt and `mret` entry and exit. It sits beside the writeback stage. The pipeline reports retirements, CSR writes and trap requests; the block returns the redirect PC and the new privilege mode one cycle later.

## Interface
- `XLEN`, 64: data width of all CSRs and PCs.
- `HARTID`, 0: constant returned by `mhartid`.
- `NUM_HPMC`, 2: number of `mhpmcounter3..` event counters (1..8).

Ports. Clock and reset come first. One clock; reset is asynchronous and active-low.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rd_addr` in 12: CSR read address.
- `rd_data` out XLEN: combinational read data.
- `rd_illegal` out 1: `rd_addr` is unimplemented.
- `wr_en` in 1: plain CSR write.
- `wr_addr` in 12: write address.
- `wr_data` in XLEN: write data, already merged for RS/RC.
- `retire` in 1: one instruction retired this cycle.
- `hpm_event` in NUM_HPMC: per-counter event strobes.
- `trap_valid` in 1: take a trap this cycle.
- `trap_is_irq` in 1: the trap is an interrupt.
- `trap_cause` in 4: cause code.
- `trap_pc` in XLEN: PC of the trapping instruction.
- `trap_tval` in XLEN: trap value.
- `mret` in 1: return from trap.
- `irq_timer`, `irq_soft`, `irq_ext` in 1 each: level interrupt lines.
- `irq_pending` out 1: an enabled interrupt is pending and `mstatus.MIE` is set.
- `irq_cause` out 4: cause code of the highest-priority pending interrupt.
- `redirect` out 1: one-cycle pulse requesting a PC redirect.
- `redirect_pc` out XLEN: target PC for the redirect.
- `priv` out 2: current privilege mode.
- `csrs` out csr_pack: full CSR snapshot.

## Operation
- **Event priority in one cycle:** `trap_valid` > `mret` > `wr_en`. A lower-priority event in the same cycle is dropped; the pipeline guarantees it is flushed.
- **Trap entry:**
  - `mepc` <= `trap_pc` with bits [1:0] cleared.
  - `mcause` <= {`trap_is_irq`, zero-extension, `trap_cause`}.
  - `mtval` <= `trap_tval`.
  - `MPIE` <= `MIE`; `MIE` <= 0; `MPP` <= `priv`; `priv` <= 3.
- **Trap target:**
  - If `mtvec.MODE` = 1 and `trap_is_irq`: `redirect_pc` = BASE + 4*`trap_cause`.
  - Otherwise: `redirect_pc` = BASE.
  - `mtvec.MODE` values 2 and 3 are treated as 0.
- **mret:** `MIE` <= `MPIE`; `MPIE` <= 1; `priv` <= `MPP`; `MPP` <= 0 (U); `redirect_pc` <= `mepc`.
- **Writes:** written values are masked by the per-CSR write masks in the package.
  - Writes to `mhartid` and `mip` are ignored.
  - Writes to unimplemented addresses are ignored.
- **mip:** read-only. MTIP/MSIP/MEIP are the `irq_*` inputs registered on every clock.
- **Interrupt priority:** MEI (11) > MSI (3) > MTI (7). A source is pending when `mip & mie` has its bit set. `irq_pending` is combinational from the registered `mip`, `mie` and `mstatus.MIE`.
- **Counters:** `mcycle` increments every cycle. `minstret` increments on `retire`. `mhpmcounterN` increments on `hpm_event[N-3]`.
  - A write to a counter in the same cycle wins over its increment. The other counters still count that cycle.
  - Counters wrap from 2^XLEN-1 to 0.
- **Reads:** combinational from current register state. No write-to-read bypass: a write appears on `rd_data` the following cycle.

## Timing
- **Reset values (all while `rst_n` low):**
  - Every CSR is 0 except `mhartid` = HARTID.
  - `priv` = 3; `redirect` = 0; `redirect_pc` = 0; `irq_pending` = 0.
- **Reset mid-operation:** reset asserting mid-trap discards the pending redirect. `redirect` is low the cycle after deassertion.
- **Latency:**
  - CSR state updates at the clock edge that samples `trap_valid`, `mret` or `wr_en`.
  - `redirect` and `redirect_pc` are registered and valid exactly one cycle after that edge, for one cycle only.
- **Back-to-back:** trap then `mret` on consecutive cycles is legal. The `mret` sees the `mepc` and `MPIE` written by the trap.
- **Interrupt lines:** an interrupt line rising at cycle t sets `mip` at t+1, so `irq_pending` is visible at t+1.

## Configuration
- `CSR_HPM_EN` defined: NUM_HPMC event counters are present at 0xB03.. and `mhpmevent` is read-as-zero.
- `CSR_HPM_EN` undefined: the counters are absent, the `hpm_event` port is ignored, those addresses read 0 with `rd_illegal` = 0, and writes to them are ignored.

## Structure
- The `csr_pkg` package holds the shared definitions:
  - CSR address constants, including the `MHPMCOUNTER3` base.
  - `MSTATUS_MASK`, `MTVEC_MASK`, `MIE_MASK`.
  - Interrupt cause codes.
  - The extended `csr_pack` struct with `minstret` and the `mtvec` mode field.
  - `mode_t`.
- One sub-module, `csr_irq_arb`: combinational priority encoder producing `irq_pending` and `irq_cause`.

## Test plan
- **Reset:** hold `rst_n` low 3 cycles, release. Expect `priv` = 3, `mhartid` = HARTID, `mcycle` = 1 one cycle after release.
- **Vectored interrupt:** `mtvec` = 0x8000_0001, `trap_valid` with `trap_is_irq` = 1, cause 7, `trap_pc` = 0x1002. Next cycle expect `redirect` = 1, `redirect_pc` = 0x8000_001C, `mepc` = 0x1000, `mcause` = 2^63+7.
- **Exception then return:** `priv` = 0, exception cause 8, then `mret`. Expect `MPP` = 0 after the trap, `priv` restored to 0, `redirect_pc` = `mepc`.
- **Simultaneous events:**
  - `wr_en` to `mscratch` with `trap_valid` in the same cycle: expect `mscratch` unchanged.
  - `wr_en` to `mcycle` = 5: expect `mcycle` = 5, then 6.
- **Interrupt arbitration:** `mie` = 0x888, `MIE` = 1, raise `irq_timer` and `irq_ext` together. Expect `irq_pending` = 1 and `irq_cause` = 11 one cycle later.
- **Counter wrap:** write `minstret` = all ones, pulse `retire`. Expect `minstret` = 0 and no effect on `mcycle`.
